// File: rtl/bcd_serial_alu_ctrl.sv
// Serial packed-BCD add/subtract sequencer.
// The operands are processed one decimal digit per clock, least significant
// digit first, through a single shared one-digit BCD adder cell.
// Subtraction uses ten's complement: each B digit is replaced by its nines
// complement, and the initial carry is set to 1.
module bcd_serial_alu_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;
  logic [IW-1:0] idx;
  logic          carry;

  logic          op_bad;
  logic          last_digit;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    bd;
  logic [4:0]    sum;
  logic [4:0]    sum_adj;
  logic [3:0]    digit;
  logic          carry_out;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Operand validity check on the live inputs, used only at acceptance
  always_comb begin
    op_bad     = has_bad_digit(a) | has_bad_digit(b);
    last_digit = (idx == IW'(DIGITS - 1));
  end

  // One-digit BCD adder cell operating on the current digit of the latched operands
  always_comb begin
    a_dig     = a_q[4*idx +: 4];
    b_dig     = b_q[4*idx +: 4];
    bd        = sub_q ? (4'd9 - b_dig) : b_dig;
    sum       = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry};
    sum_adj   = sum - 5'd10;
    carry_out = (sum > 5'd9);
    digit     = carry_out ? sum_adj[3:0] : sum[3:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status decode
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = op_bad ? DONE : RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, digit write-back and flag updates
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            idx    <= '0;
            carry  <= sub;
            result <= '0;
            err    <= op_bad;
            if (op_bad) cout <= 1'b0;
          end
        end
        RUN: begin
          result[4*idx +: 4] <= digit;
          carry              <= carry_out;
          if (last_digit) cout <= sub_q ? ~carry_out : carry_out;
          else            idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Self-checking bench for bcd_serial_alu_ctrl with DIGITS=4.
// It runs the directed cases first and then random operations. The expected
// results come from an integer-arithmetic model of decimal add/subtract.
module tb_bcd_serial_alu_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         err;

  int checks   = 0;
  int failures = 0;

  bcd_serial_alu_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Decimal reference: plain integer arithmetic modulo 10^DIGITS
  task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                       output logic [W-1:0] r, output logic c, output logic e);
    int ia, ib, m;
    m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    e = any_bad(oa) | any_bad(ob);
    if (e) begin
      r = '0;
      c = 1'b0;
    end else begin
      ia = bcd2int(oa);
      ib = bcd2int(ob);
      if (!osub) begin
        r = int2bcd((ia + ib) % m);
        c = (ia + ib) >= m;
      end else if (ia >= ib) begin
        r = int2bcd(ia - ib);
        c = 1'b0;
      end else begin
        r = int2bcd(m - (ib - ia));
        c = 1'b1;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_bcd(input logic allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Starts one operation from an IDLE negedge and waits for done.
  // The task returns at the negedge after the done cycle, with the DUT in IDLE.
  task automatic apply_stimulus(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                input logic osub, input bit glitch);
    logic [W-1:0] exp_r;
    logic         exp_c, exp_e;
    int           n;
    int           lat;
    bit           got;
    model(oa, ob, osub, exp_r, exp_c, exp_e);
    lat   = exp_e ? 1 : DIGITS + 1;
    a     = oa;
    b     = ob;
    sub   = osub;
    start = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (done) got = 1;
      start = glitch && (n == 2);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
    end
    start = 1'b0;
    check("done_latency", n, lat);
    check_output(exp_r, exp_c, exp_e);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(exp_r));
  endtask

  task automatic check_output(input logic [W-1:0] exp_r, input logic exp_c, input logic exp_e);
    check("result", 32'(result), 32'(exp_r));
    check("cout", 32'(cout), 32'(exp_c));
    check("err", 32'(err), 32'(exp_e));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_output('0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    apply_stimulus(16'h1234, 16'h8766, 1'b0, 1'b0);
    apply_stimulus(16'h0500, 16'h0123, 1'b1, 1'b0);
    apply_stimulus(16'h0123, 16'h0500, 1'b1, 1'b0);
    apply_stimulus(16'h00A0, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    apply_stimulus(16'h0042, 16'h0042, 1'b1, 1'b0);
    apply_stimulus(16'h2468, 16'h1357, 1'b0, 1'b1);
    check("no_extra_done", 32'(done), 32'd0);

    $display("[TB] reset during RUN");
    a     = 16'h1234;
    b     = 16'h1111;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    apply_stimulus(16'h9999, 16'h0001, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int k = 0; k < 40; k++)
      apply_stimulus(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
